dpll_loop_controller: RTL and testbench
=======================================

Name: dpll_loop_controller

Overview:
- Supervises the DPLL loop around the random-walk filter.
- Takes the filter's Positive/Negative correction pulses and paces them onto the DCO as Advance/Retard commands, with a minimum gap between commands.
- Measures correction density per bit window and switches the filter configuration between acquisition (short filter) and tracking (long filter).
- Sits between the random-walk filter and the DCO; also reports lock status.

Parameters:
- WIN_BITS, 64: BitStrobe pulses per measurement window.
- LOCK_THRESH, 2: max corrections in a window for that window to count as "good".
- LOCK_WINDOWS, 4: consecutive good windows needed to enter TRACK.
- UNLOCK_THRESH, 8: corrections in a window that force a return to ACQUIRE.
- CORR_GAP, 16: min MainClock cycles between successive Advance/Retard pulses.
- CNT_W, 8: width of the window correction counter.
- HOLD_TIMEOUT, 1024: MainClock cycles without BitStrobe before HOLD (used only with the optional feature).

Ports:
- MainClock, in, 1: system clock.
- nReset, in, 1: asynchronous active-low reset.
- Enable, in, 1: loop enable.
- BitStrobe, in, 1: one-cycle pulse per received bit.
- Positive, in, 1: filter "positive shift" pulse.
- Negative, in, 1: filter "negative shift" pulse.
- Advance, out, 1: one-cycle DCO advance command.
- Retard, out, 1: one-cycle DCO retard command.
- FilterSel, out, 2: filter config. 00 = acquire/short, 01 = track/long, 10 = hold.
- Locked, out, 1: loop lock flag.
- State, out, 2: FSM state. 00 IDLE, 01 ACQUIRE, 10 TRACK, 11 HOLD.
- CorrCount, out, CNT_W: correction count latched from the last completed window.

Behaviour:
- Reset (nReset=0, asynchronous): all outputs are 0 and State=IDLE. Pending count, gap timer, window counter, good-window counter and timeout counter are all cleared.
- Enable=0: from any state, enter IDLE at the next edge. Outputs and counters clear exactly as at reset. Enable=1 in IDLE moves to ACQUIRE at the next edge.
- Pending correction counter: 4-bit signed, saturating at +7 and -7.
  - Positive alone: +1. Negative alone: -1. Both in the same cycle: no change.
  - At saturation, further requests in the same direction are dropped.
- Issue rules:
  - Advance/Retard are registered.
  - If pending != 0 and the gap timer is 0 at edge k: assert Advance (pending > 0) or Retard (pending < 0) for cycle k+1. Pending moves one step toward 0 and the gap timer loads CORR_GAP-1.
  - A Positive sampled at edge k with pending=0 and gap expired therefore produces Advance in cycle k+2.
  - Advance and Retard are never asserted together.
  - A request arriving in the same cycle as an issue is accumulated, not lost.
- Window:
  - Counts BitStrobe pulses; a window ends on the WIN_BITS-th strobe.
  - Correction events (Positive | Negative, counted from the inputs, both counted as 1) saturate at 2^CNT_W-1.
  - At window end the count is latched into CorrCount and the counter restarts at 0. An event in the window-end cycle belongs to the ending window.
- ACQUIRE: FilterSel=00, Locked=0. At each window end:
  - count <= LOCK_THRESH: good-window counter +1.
  - otherwise: good-window counter cleared.
  - Reaching LOCK_WINDOWS: enter TRACK at that edge.
- TRACK: FilterSel=01, Locked=1. A window end with count >= UNLOCK_THRESH returns to ACQUIRE, clears the good-window counter and drops Locked at the same edge.
- FilterSel changes take effect the cycle after the state change. Pending corrections are kept across ACQUIRE/TRACK transitions.

Optional Feature:
- Macro: DPLL_HOLDOVER_EN.
- With the macro:
  - In TRACK, if HOLD_TIMEOUT consecutive cycles pass with no BitStrobe, enter HOLD.
  - In HOLD: FilterSel=10, Locked stays 1, pending is cleared, Positive/Negative are ignored, and Advance/Retard stay 0.
  - The first BitStrobe in HOLD returns to TRACK with a fresh window.
- Without the macro: no timeout counter, State=11 is unreachable, and HOLD_TIMEOUT is unused.

Decomposition:
- Shared package dpll_pkg holds:
  - the state encoding constants;
  - the FilterSel encodings (FSEL_ACQ, FSEL_TRACK, FSEL_HOLD);
  - the pending counter width (4) and its saturation limits (+/-7).
- One sub-module, dpll_correction_pacer, holds the pending counter, gap timer and Advance/Retard registers. Its inputs are Positive, Negative and a clear signal.

Test Plan:
- Single Positive at cycle 10, idle loop -> Advance high only in cycle 12; Retard stays 0.
- 5 Positive pulses on consecutive cycles, CORR_GAP=16 -> 5 Advance pulses spaced exactly 16 cycles apart, then pending=0.
- 10 Negative pulses plus 3 simultaneous Positive/Negative pairs -> pending saturates at -7; exactly 7 Retard pulses; the pairs cause no change.
- ACQUIRE, 4 windows of 64 strobes each with 1 correction -> TRACK, Locked=1 and FilterSel=01 after the 4th window end. Next window with 8 corrections -> ACQUIRE, Locked=0, CorrCount=8.
- Enable dropped mid-TRACK with pending=3 -> State=IDLE next cycle; all outputs 0; no further Advance. Same with nReset asserted asynchronously mid-cycle.
- With DPLL_HOLDOVER_EN, TRACK with no BitStrobe for 1024 cycles -> HOLD and FilterSel=10. Positive pulses in HOLD produce no Advance; one BitStrobe returns to TRACK.

Source files
------------

// File: rtl/dpll_pkg.sv
// -----------------------------------------------------------------------------
// dpll_pkg
// Shared definitions for the DPLL loop controller slice:
//   - FSM state encoding (IDLE/ACQUIRE/TRACK/HOLD)
//   - FilterSel encodings (FSEL_ACQ, FSEL_TRACK, FSEL_HOLD)
//   - pending-correction counter width and its symmetric saturation limits
//   - stateToFsel / satPending helper functions
// No ports (package).
// -----------------------------------------------------------------------------
package dpll_pkg;

  typedef logic [1:0] dpllState_t;
  typedef logic [1:0] filterSel_t;

  localparam dpllState_t ST_IDLE    = 2'b00;
  localparam dpllState_t ST_ACQUIRE = 2'b01;
  localparam dpllState_t ST_TRACK   = 2'b10;
  localparam dpllState_t ST_HOLD    = 2'b11;

  localparam filterSel_t FSEL_ACQ   = 2'b00;
  localparam filterSel_t FSEL_TRACK = 2'b01;
  localparam filterSel_t FSEL_HOLD  = 2'b10;

  // Pending corrections: 4-bit two's complement, clamped to +/-7 so the
  // counter never reaches the asymmetric -8 code.
  localparam int PEND_W = 4;
  localparam logic signed [PEND_W-1:0] PEND_MAX = 4'sd7;
  localparam logic signed [PEND_W-1:0] PEND_MIN = -4'sd7;

  // Filter configuration selected by a given FSM state (IDLE uses the
  // acquisition filter).
  function automatic filterSel_t stateToFsel(input dpllState_t st);
    filterSel_t fsel;
    case (st)
      ST_IDLE:    fsel = FSEL_ACQ;
      ST_ACQUIRE: fsel = FSEL_ACQ;
      ST_TRACK:   fsel = FSEL_TRACK;
      ST_HOLD:    fsel = FSEL_HOLD;
      default:    fsel = FSEL_ACQ;
    endcase
    return fsel;
  endfunction

  // Clamp a sign-extended pending sum back into the +/-7 range.
  function automatic logic signed [PEND_W-1:0] satPending(input logic signed [PEND_W+1:0] sum);
    logic signed [PEND_W-1:0] res;
    if (sum > 6'sd7) begin
      res = PEND_MAX;
    end else if (sum < -6'sd7) begin
      res = PEND_MIN;
    end else begin
      res = sum[PEND_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpll_loop_controller_if.sv
// -----------------------------------------------------------------------------
// dpll_loop_controller_if
// Groups the loop controller's control/status signals.
//   Enable, BitStrobe, Positive, Negative : driven by master (filter side)
//   Advance, Retard                       : DCO commands, driven by slave
//   FilterSel[1:0], Locked, State[1:0]    : status, driven by slave
//   CorrCount[CNT_W-1:0]                  : last window's correction count
// Modports: master (environment), slave (dpll_loop_controller).
// -----------------------------------------------------------------------------
interface dpll_loop_controller_if #(
  parameter int CNT_W = 8
);
  logic             Enable;
  logic             BitStrobe;
  logic             Positive;
  logic             Negative;
  logic             Advance;
  logic             Retard;
  logic [1:0]       FilterSel;
  logic             Locked;
  logic [1:0]       State;
  logic [CNT_W-1:0] CorrCount;

  modport master (
    output Enable, BitStrobe, Positive, Negative,
    input  Advance, Retard, FilterSel, Locked, State, CorrCount
  );

  modport slave (
    input  Enable, BitStrobe, Positive, Negative,
    output Advance, Retard, FilterSel, Locked, State, CorrCount
  );
endinterface

// File: rtl/dpll_correction_pacer.sv
// -----------------------------------------------------------------------------
// dpll_correction_pacer
// Accumulates Positive/Negative requests in a saturating signed pending
// counter and releases them one at a time as registered Advance/Retard
// pulses, no closer than CORR_GAP MainClock cycles apart.
// Ports:
//   MainClock, nReset (async, active low)
//   Clear    : synchronous clear of pending, gap timer and outputs
//   Positive : +1 request, Negative : -1 request (both together cancel)
//   Advance, Retard : one-cycle registered DCO commands (mutually exclusive)
// -----------------------------------------------------------------------------
module dpll_correction_pacer
  import dpll_pkg::*;
#(
  parameter int CORR_GAP = 16
) (
  input  logic MainClock,
  input  logic nReset,
  input  logic Clear,
  input  logic Positive,
  input  logic Negative,
  output logic Advance,
  output logic Retard
);

  localparam int GAP_W = (CORR_GAP > 1) ? $clog2(CORR_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CORR_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic signed [PEND_W-1:0] pending_r;
  logic [GAP_W-1:0]         gapTimer_r;
  logic                     advance_r;
  logic                     retard_r;

  logic                     issue_s;
  logic signed [PEND_W+1:0] issueAdj_s;
  logic signed [PEND_W+1:0] reqAdj_s;
  logic signed [PEND_W+1:0] sum_s;
  logic signed [PEND_W-1:0] pendNext_s;
  logic [GAP_W-1:0]         gapNext_s;

  // Issue decision and next pending value. The issue step and a new request
  // are combined in one sum so a request arriving on an issue cycle is kept;
  // saturation after the sum drops only requests that would exceed +/-7.
  always_comb begin
    issue_s = (pending_r != 4'sd0) && (gapTimer_r == '0);

    if (issue_s) begin
      if (pending_r > 4'sd0) begin
        issueAdj_s = -6'sd1;
      end else begin
        issueAdj_s = 6'sd1;
      end
    end else begin
      issueAdj_s = 6'sd0;
    end

    if (Positive && !Negative) begin
      reqAdj_s = 6'sd1;
    end else if (Negative && !Positive) begin
      reqAdj_s = -6'sd1;
    end else begin
      reqAdj_s = 6'sd0;
    end

    sum_s      = {{2{pending_r[PEND_W-1]}}, pending_r} + issueAdj_s + reqAdj_s;
    pendNext_s = satPending(sum_s);

    if (issue_s) begin
      gapNext_s = GAP_LOAD;
    end else if (gapTimer_r != '0) begin
      gapNext_s = gapTimer_r - GAP_ONE;
    end else begin
      gapNext_s = gapTimer_r;
    end
  end

  // Pending accumulator, gap timer and registered DCO commands.
  always_ff @(posedge MainClock or negedge nReset) begin
    if (!nReset) begin
      pending_r  <= 4'sd0;
      gapTimer_r <= '0;
      advance_r  <= 1'b0;
      retard_r   <= 1'b0;
    end else if (Clear) begin
      pending_r  <= 4'sd0;
      gapTimer_r <= '0;
      advance_r  <= 1'b0;
      retard_r   <= 1'b0;
    end else begin
      pending_r  <= pendNext_s;
      gapTimer_r <= gapNext_s;
      advance_r  <= issue_s && (pending_r > 4'sd0);
      retard_r   <= issue_s && (pending_r < 4'sd0);
    end
  end

  assign Advance = advance_r;
  assign Retard  = retard_r;

endmodule

// File: rtl/dpll_loop_controller.sv
// -----------------------------------------------------------------------------
// dpll_loop_controller
// Supervises the DPLL loop between the random-walk filter and the DCO:
// paces filter corrections onto the DCO (dpll_correction_pacer), measures
// correction density per WIN_BITS-strobe window and switches the filter
// between acquisition and tracking, reporting lock.
// Ports:
//   MainClock, nReset (async, active low)
//   bus : dpll_loop_controller_if.slave
//         in  Enable, BitStrobe, Positive, Negative
//         out Advance, Retard, FilterSel, Locked, State, CorrCount
// Optional build macro: DPLL_HOLDOVER_EN adds the HOLD state, entered from
// TRACK after HOLD_TIMEOUT cycles without a BitStrobe. Without it, HOLD is
// unreachable and HOLD_TIMEOUT is unused.
// -----------------------------------------------------------------------------
module dpll_loop_controller
  import dpll_pkg::*;
#(
  parameter int WIN_BITS      = 64,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_WINDOWS  = 4,
  parameter int UNLOCK_THRESH = 8,
  parameter int CORR_GAP      = 16,
  parameter int CNT_W         = 8,
  parameter int HOLD_TIMEOUT  = 1024
) (
  input logic                   MainClock,
  input logic                   nReset,
  dpll_loop_controller_if.slave bus
);

  localparam int BIT_W  = (WIN_BITS > 1) ? $clog2(WIN_BITS) : 1;
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(WIN_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE     = BIT_W'(1);
  localparam logic [CNT_W-1:0]  CORR_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CORR_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LOCK_TH_C   = CNT_W'(LOCK_THRESH);
  localparam logic [CNT_W-1:0]  UNLOCK_TH_C = CNT_W'(UNLOCK_THRESH);
  localparam logic [GOOD_W-1:0] GOOD_ONE    = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_WIN_C  = GOOD_W'(LOCK_WINDOWS);

  dpllState_t        state_r;
  dpllState_t        nextState_s;
  logic [BIT_W-1:0]  bitCnt_r;
  logic [CNT_W-1:0]  corrCnt_r;
  logic [CNT_W-1:0]  corrCount_r;
  logic [GOOD_W-1:0] goodCnt_r;
  logic [GOOD_W-1:0] goodNext_s;
  logic [GOOD_W-1:0] goodInc_s;
  filterSel_t        filterSel_r;
  logic              locked_r;

  logic              loopActive_s;
  logic              loopClear_s;
  logic              corrEvent_s;
  logic [CNT_W-1:0]  corrInc_s;
  logic              windowEnd_s;
  logic              advance_s;
  logic              retard_s;

`ifdef DPLL_HOLDOVER_EN
  localparam int HOLD_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  logic [HOLD_W-1:0] holdCnt_r;
`endif

  // Window measurement only runs while the loop is acquiring or tracking.
  assign loopActive_s = (state_r == ST_ACQUIRE) || (state_r == ST_TRACK);

  // Pacer and window counters are held clear in IDLE/HOLD and on the edge
  // that enters either of them, so no command leaks out after the loop stops.
  assign loopClear_s = (state_r == ST_IDLE) || (state_r == ST_HOLD) ||
                       (nextState_s == ST_IDLE) || (nextState_s == ST_HOLD);

  // Window-end detection, saturating event count and next-state logic.
  // corrInc_s already includes an event in the window-end cycle.
  always_comb begin
    corrEvent_s = bus.Positive | bus.Negative;
    if (corrEvent_s && (corrCnt_r != CORR_MAX)) begin
      corrInc_s = corrCnt_r + CORR_ONE;
    end else begin
      corrInc_s = corrCnt_r;
    end
    windowEnd_s = loopActive_s && bus.BitStrobe && (bitCnt_r == BIT_LAST);
    goodInc_s   = goodCnt_r + GOOD_ONE;
    nextState_s = state_r;
    goodNext_s  = goodCnt_r;

    if (!bus.Enable) begin
      nextState_s = ST_IDLE;
      goodNext_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          nextState_s = ST_ACQUIRE;
          goodNext_s  = '0;
        end
        ST_ACQUIRE: begin
          if (windowEnd_s) begin
            if (corrInc_s <= LOCK_TH_C) begin
              if (goodInc_s >= LOCK_WIN_C) begin
                nextState_s = ST_TRACK;
                goodNext_s  = '0;
              end else begin
                goodNext_s = goodInc_s;
              end
            end else begin
              goodNext_s = '0;
            end
          end else begin
            nextState_s = ST_ACQUIRE;
          end
        end
        ST_TRACK: begin
          if (windowEnd_s && (corrInc_s >= UNLOCK_TH_C)) begin
            nextState_s = ST_ACQUIRE;
            goodNext_s  = '0;
          end
`ifdef DPLL_HOLDOVER_EN
          else if (!bus.BitStrobe && (holdCnt_r == HOLD_LAST)) begin
            nextState_s = ST_HOLD;
          end
`endif
          else begin
            nextState_s = ST_TRACK;
          end
        end
        ST_HOLD: begin
`ifdef DPLL_HOLDOVER_EN
          if (bus.BitStrobe) begin
            nextState_s = ST_TRACK;
          end else begin
            nextState_s = ST_HOLD;
          end
`else
          nextState_s = ST_IDLE;
`endif
        end
        default: begin
          nextState_s = ST_IDLE;
          goodNext_s  = '0;
        end
      endcase
    end
  end

  // FSM state and good-window counter.
  always_ff @(posedge MainClock or negedge nReset) begin
    if (!nReset) begin
      state_r   <= ST_IDLE;
      goodCnt_r <= '0;
    end else begin
      state_r   <= nextState_s;
      goodCnt_r <= goodNext_s;
    end
  end

  // Strobe counter and in-window correction counter.
  always_ff @(posedge MainClock or negedge nReset) begin
    if (!nReset) begin
      bitCnt_r  <= '0;
      corrCnt_r <= '0;
    end else if (loopClear_s || windowEnd_s) begin
      bitCnt_r  <= '0;
      corrCnt_r <= '0;
    end else begin
      if (bus.BitStrobe) begin
        bitCnt_r <= bitCnt_r + BIT_ONE;
      end else begin
        bitCnt_r <= bitCnt_r;
      end
      corrCnt_r <= corrInc_s;
    end
  end

  // Status outputs. FilterSel follows the state one cycle late; Locked
  // follows the next state so it rises and falls with the transition edge.
  always_ff @(posedge MainClock or negedge nReset) begin
    if (!nReset) begin
      corrCount_r <= '0;
      filterSel_r <= FSEL_ACQ;
      locked_r    <= 1'b0;
    end else if (!bus.Enable) begin
      corrCount_r <= '0;
      filterSel_r <= FSEL_ACQ;
      locked_r    <= 1'b0;
    end else begin
      if (windowEnd_s) begin
        corrCount_r <= corrInc_s;
      end else begin
        corrCount_r <= corrCount_r;
      end
      filterSel_r <= stateToFsel(state_r);
      locked_r    <= (nextState_s == ST_TRACK) || (nextState_s == ST_HOLD);
    end
  end

`ifdef DPLL_HOLDOVER_EN
  // Counts strobe-less cycles while staying in TRACK.
  always_ff @(posedge MainClock or negedge nReset) begin
    if (!nReset) begin
      holdCnt_r <= '0;
    end else if ((state_r == ST_TRACK) && (nextState_s == ST_TRACK) && !bus.BitStrobe) begin
      holdCnt_r <= holdCnt_r + HOLD_ONE;
    end else begin
      holdCnt_r <= '0;
    end
  end
`endif

  dpll_correction_pacer #(
    .CORR_GAP (CORR_GAP)
  ) uPacer (
    .MainClock (MainClock),
    .nReset    (nReset),
    .Clear     (loopClear_s),
    .Positive  (bus.Positive),
    .Negative  (bus.Negative),
    .Advance   (advance_s),
    .Retard    (retard_s)
  );

  assign bus.Advance   = advance_s;
  assign bus.Retard    = retard_s;
  assign bus.FilterSel = filterSel_r;
  assign bus.Locked    = locked_r;
  assign bus.State     = state_r;
  assign bus.CorrCount = corrCount_r;

endmodule

// File: tb/tb_dpll_loop_controller.sv
// -----------------------------------------------------------------------------
// tb_dpll_loop_controller
// Directed scenarios plus a randomized phase, all outputs compared every
// cycle against a behavioural model of the loop controller rules.
// Honours DPLL_HOLDOVER_EN for the holdover scenario and model.
// -----------------------------------------------------------------------------
module tb_dpll_loop_controller;

  localparam int WIN_BITS      = 64;
  localparam int LOCK_THRESH   = 2;
  localparam int LOCK_WINDOWS  = 4;
  localparam int UNLOCK_THRESH = 8;
  localparam int CORR_GAP      = 16;
  localparam int CNT_W         = 8;
  localparam int HOLD_TIMEOUT  = 1024;
  localparam int CORR_SAT      = (1 << CNT_W) - 1;

  logic MainClock = 1'b0;
  logic nReset    = 1'b0;

  dpll_loop_controller_if #(.CNT_W(CNT_W)) bus();

  dpll_loop_controller #(
    .WIN_BITS      (WIN_BITS),
    .LOCK_THRESH   (LOCK_THRESH),
    .LOCK_WINDOWS  (LOCK_WINDOWS),
    .UNLOCK_THRESH (UNLOCK_THRESH),
    .CORR_GAP      (CORR_GAP),
    .CNT_W         (CNT_W),
    .HOLD_TIMEOUT  (HOLD_TIMEOUT)
  ) dut (
    .MainClock (MainClock),
    .nReset    (nReset),
    .bus       (bus)
  );

  always #5 MainClock = ~MainClock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int advTimes[$];
  int retTimes[$];

  // model state: 0 IDLE, 1 ACQUIRE, 2 TRACK, 3 HOLD
  int mSt, mPend, mGap, mBits, mCorr, mGood, mLat, mAdv, mRet, mFsel, mLock, mHold;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    mSt = 0; mPend = 0; mGap = 0; mBits = 0; mCorr = 0; mGood = 0;
    mLat = 0; mAdv = 0; mRet = 0; mFsel = 0; mLock = 0; mHold = 0;
  endtask

  // One clock edge of the loop rules, using the inputs present at the edge.
  task automatic modelEdge();
    int nst, c, p, pos, neg;
    bit wend, clr, iss, strobe;
    if (!nReset) begin
      modelReset();
      return;
    end
    pos    = bus.Positive ? 1 : 0;
    neg    = bus.Negative ? 1 : 0;
    strobe = bus.BitStrobe;
    c = mCorr + (((pos + neg) > 0) ? 1 : 0);
    if (c > CORR_SAT) c = CORR_SAT;
    wend = (mSt == 1 || mSt == 2) && strobe && (mBits == WIN_BITS - 1);
    nst = mSt;
    if (!bus.Enable) begin
      nst = 0;
    end else if (mSt == 0) begin
      nst = 1;
    end else if (mSt == 1) begin
      if (wend) begin
        if (c <= LOCK_THRESH) mGood++; else mGood = 0;
        if (mGood >= LOCK_WINDOWS) begin nst = 2; mGood = 0; end
      end
    end else if (mSt == 2) begin
      if (wend && c >= UNLOCK_THRESH) begin nst = 1; mGood = 0; end
`ifdef DPLL_HOLDOVER_EN
      else if (!strobe && mHold == HOLD_TIMEOUT - 1) nst = 3;
`endif
    end else if (mSt == 3) begin
      if (strobe) nst = 2;
    end
    if (nst == 0) mGood = 0;
    mHold = (mSt == 2 && nst == 2 && !strobe) ? mHold + 1 : 0;

    mFsel = !bus.Enable ? 0 : (mSt == 2 ? 1 : (mSt == 3 ? 2 : 0));
    mLock = (nst == 2 || nst == 3) ? 1 : 0;
    if (nst == 0) mLat = 0;
    else if (wend) mLat = c;

    clr = (mSt == 0 || mSt == 3 || nst == 0 || nst == 3);
    if (clr) begin
      mPend = 0; mGap = 0; mAdv = 0; mRet = 0; mBits = 0; mCorr = 0;
    end else begin
      iss  = (mPend != 0) && (mGap == 0);
      mAdv = (iss && mPend > 0) ? 1 : 0;
      mRet = (iss && mPend < 0) ? 1 : 0;
      p = mPend;
      if (iss) p = p + ((mPend > 0) ? -1 : 1);
      p = p + pos - neg;
      if (p > 7) p = 7;
      if (p < -7) p = -7;
      mPend = p;
      mGap  = iss ? CORR_GAP - 1 : ((mGap > 0) ? mGap - 1 : 0);
      if (wend) begin
        mBits = 0; mCorr = 0;
      end else begin
        if (strobe) mBits++;
        mCorr = c;
      end
    end
    mSt = nst;
  endtask

  task automatic compareAll();
    checkVal("State",     32'(bus.State),     mSt);
    checkVal("Advance",   32'(bus.Advance),   mAdv);
    checkVal("Retard",    32'(bus.Retard),    mRet);
    checkVal("FilterSel", 32'(bus.FilterSel), mFsel);
    checkVal("Locked",    32'(bus.Locked),    mLock);
    checkVal("CorrCount", 32'(bus.CorrCount), mLat);
    checkVal("AdvRetExcl", 32'(bus.Advance & bus.Retard), 32'd0);
    if (bus.Advance === 1'b1) advTimes.push_back(cyc);
    if (bus.Retard === 1'b1) retTimes.push_back(cyc);
  endtask

  task automatic step();
    @(posedge MainClock);
    cyc++;
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    bus.BitStrobe = 1'b0; bus.Positive = 1'b0; bus.Negative = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // One full window, strobing every cycle, with nCorr alternating corrections.
  task automatic runWindow(input int nCorr);
    for (int i = 0; i < WIN_BITS; i++) begin
      bus.BitStrobe = 1'b1;
      bus.Positive  = (i < 2 * nCorr) && (i % 4 == 0);
      bus.Negative  = (i < 2 * nCorr) && (i % 4 == 2);
      step();
    end
    bus.BitStrobe = 1'b0; bus.Positive = 1'b0; bus.Negative = 1'b0;
  endtask

  task automatic restartLoop();
    bus.Enable = 1'b0;
    idle(1);
    bus.Enable = 1'b1;
    idle(1);
  endtask

  initial begin
    int k, nAdv, rate;
    bus.Enable = 1'b0; bus.BitStrobe = 1'b0; bus.Positive = 1'b0; bus.Negative = 1'b0;
    modelReset();
    #1;
    checkVal("rst_State", 32'(bus.State), 32'd0);
    idle(3);
    nReset = 1'b1;
    bus.Enable = 1'b1;
    idle(20);
    checkVal("acq_State", 32'(bus.State), 32'd1);

    // single Positive -> Advance exactly two cycles later, once
    advTimes.delete(); retTimes.delete();
    bus.Positive = 1'b1; step(); k = cyc; bus.Positive = 1'b0;
    idle(30);
    checkVal("single_nAdv", advTimes.size(), 32'd1);
    if (advTimes.size() > 0) checkVal("single_lat", advTimes[0] - k, 32'd1);
    checkVal("single_nRet", retTimes.size(), 32'd0);

    // five back-to-back Positives -> five Advances 16 cycles apart
    advTimes.delete();
    bus.Positive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) k = cyc;
    end
    bus.Positive = 1'b0;
    idle(100);
    checkVal("five_nAdv", advTimes.size(), 32'd5);
    if (advTimes.size() > 0) checkVal("five_first", advTimes[0] - k, 32'd1);
    for (int i = 1; i < advTimes.size(); i++)
      checkVal("five_gap", advTimes[i] - advTimes[i-1], CORR_GAP);

    // saturation at -7 while the gap timer is running; pairs change nothing
    advTimes.delete(); retTimes.delete();
    bus.Positive = 1'b1; step(); bus.Positive = 1'b0; step();
    bus.Negative = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.Positive = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle(150);
    checkVal("sat_nAdv", advTimes.size(), 32'd1);
    checkVal("sat_nRet", retTimes.size(), 32'd7);

    // lock after four good windows, unlock on a busy window
    restartLoop();
    for (int w = 0; w < LOCK_WINDOWS; w++) runWindow(1);
    checkVal("lock_State", 32'(bus.State), 32'd2);
    checkVal("lock_Locked", 32'(bus.Locked), 32'd1);
    idle(1);
    checkVal("lock_FilterSel", 32'(bus.FilterSel), 32'd1);
    runWindow(8);
    checkVal("unlock_State", 32'(bus.State), 32'd1);
    checkVal("unlock_Locked", 32'(bus.Locked), 32'd0);
    checkVal("unlock_CorrCount", 32'(bus.CorrCount), 32'd8);

    // Enable dropped in TRACK with corrections pending
    for (int w = 0; w < LOCK_WINDOWS; w++) runWindow(0);
    checkVal("relock_State", 32'(bus.State), 32'd2);
    bus.Positive = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.Positive = 1'b0;
    advTimes.delete();
    bus.Enable = 1'b0;
    step();
    checkVal("dis_State", 32'(bus.State), 32'd0);
    checkVal("dis_outs", {bus.Advance, bus.Retard, bus.Locked, bus.FilterSel, bus.CorrCount}, 32'd0);
    idle(40);
    checkVal("dis_nAdv", advTimes.size(), 32'd0);

    // asynchronous reset mid-cycle in TRACK
    bus.Enable = 1'b1;
    idle(1);
    for (int w = 0; w < LOCK_WINDOWS; w++) runWindow(0);
    bus.Positive = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.Positive = 1'b0;
    advTimes.delete();
    #2 nReset = 1'b0;
    modelReset();
    #1;
    checkVal("arst_State", 32'(bus.State), 32'd0);
    checkVal("arst_outs", {bus.Advance, bus.Retard, bus.Locked, bus.FilterSel, bus.CorrCount}, 32'd0);
    idle(3);
    nReset = 1'b1;
    idle(40);
    checkVal("arst_nAdv", advTimes.size(), 32'd0);

`ifdef DPLL_HOLDOVER_EN
    // holdover: no strobes for HOLD_TIMEOUT cycles in TRACK
    restartLoop();
    for (int w = 0; w < LOCK_WINDOWS; w++) runWindow(0);
    idle(HOLD_TIMEOUT - 1);
    checkVal("hold_pre", 32'(bus.State), 32'd2);
    idle(1);
    checkVal("hold_State", 32'(bus.State), 32'd3);
    idle(1);
    checkVal("hold_FilterSel", 32'(bus.FilterSel), 32'd2);
    checkVal("hold_Locked", 32'(bus.Locked), 32'd1);
    advTimes.delete();
    bus.Positive = 1'b1;
    for (int i = 0; i < 5; i++) step();
    idle(40);
    checkVal("hold_nAdv", advTimes.size(), 32'd0);
    bus.BitStrobe = 1'b1; step(); bus.BitStrobe = 1'b0;
    checkVal("hold_exit", 32'(bus.State), 32'd2);
    idle(2);
`endif

    // randomized phase, varying correction density
    rate = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 0;
          1: rate = 80;
          default: rate = 6;
        endcase
      end
      bus.Enable    = ($urandom_range(0, 999) != 0);
      bus.BitStrobe = ($urandom_range(0, 1) == 1);
      bus.Positive  = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
      bus.Negative  = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
      step();
    end
    nAdv = advTimes.size();
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
